// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions:
// control-flow opcodes and redirect FSM states.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } redir_state_t;

  function automatic logic is_jump(
    input logic [6:0] op
  );
    return (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

  function automatic logic is_ctrl(
    input logic [6:0] op
  );
    return (op == OPC_BRANCH) || is_jump(op);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating event counter with synchronous
// clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up to all-ones and stick there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect sequencer: registered PC
// redirect, flush pulse train, branch stats.
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             stall_req,
  input  logic             cnt_clr,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             flush_o,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] jmp_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(1);

  redir_state_t  state;
  redir_state_t  state_d;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_d;
  logic          accept;
  logic          load_tgt;
  logic          inc_br;
  logic          inc_tk;
  logic          inc_jmp;

  // Wrong-path work is never accepted: only IDLE sees EX
  assign accept = ex_valid & ~stall_req
                & (state == IDLE) & is_ctrl(opcode);

  assign inc_br  = accept & (opcode == OPC_BRANCH);
  assign inc_tk  = inc_br & br_taken;
  assign inc_jmp = accept & is_jump(opcode);

  // State, flush counter and redirect target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fcnt      <= '0;
      pc_target <= '0;
    end else begin
      state <= state_d;
      fcnt  <= fcnt_d;
      if (load_tgt) begin
        pc_target <= br_target;
      end
    end
  end

  // Next state; outputs decode from registered state only
  always_comb begin
    state_d  = state;
    fcnt_d   = fcnt;
    load_tgt = 1'b0;
    pc_sel   = 1'b0;
    flush_o  = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && br_taken) begin
          state_d  = REDIRECT;
          load_tgt = 1'b1;
        end
      end
      REDIRECT: begin
        pc_sel  = 1'b1;
        flush_o = 1'b1;
        busy    = 1'b1;
        if (!stall_req) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        busy    = 1'b1;
        if (!stall_req) begin
          if (fcnt == FLUSH_LAST) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (inc_br),
    .count (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_tk_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (inc_tk),
    .count (br_taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_jmp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (inc_jmp),
    .count (jmp_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed
// scenarios plus random traffic vs. a model.
module tb_branch_redirect_ctrl;

  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [6:0]    opcode;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          stall_req;
  logic          cnt_clr;
  logic          pc_sel;
  logic [31:0]   pc_target;
  logic          flush_o;
  logic          busy;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] br_taken_cnt;
  logic [CW-1:0] jmp_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Model: flush cycles left (0 = idle), target, counts
  int          m_left;
  logic [31:0] m_tgt;
  int          m_br;
  int          m_tk;
  int          m_jmp;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .opcode       (opcode),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .stall_req    (stall_req),
    .cnt_clr      (cnt_clr),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .flush_o      (flush_o),
    .busy         (busy),
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt),
    .jmp_cnt      (jmp_cnt)
  );

  task automatic model_reset();
    m_left = 0;
    m_tgt  = '0;
    m_br   = 0;
    m_tk   = 0;
    m_jmp  = 0;
  endtask

  // One clock: apply model rules at the edge, return at negedge
  task automatic tick();
    bit ctrl;
    bit acc;
    @(posedge clk);
    ctrl = (opcode == BR) || (opcode == JAL) || (opcode == JALR);
    acc  = ex_valid && !stall_req && (m_left == 0) && ctrl;
    if (rst) begin
      model_reset();
    end else begin
      if (cnt_clr) begin
        m_br = 0; m_tk = 0; m_jmp = 0;
      end else if (acc) begin
        if (opcode == BR) begin
          if (m_br < MAX) m_br++;
          if (br_taken && m_tk < MAX) m_tk++;
        end else if (m_jmp < MAX) begin
          m_jmp++;
        end
      end
      if (m_left == 0) begin
        if (acc && br_taken) begin
          m_left = FC;
          m_tgt  = br_target;
        end
      end else if (!stall_req) begin
        m_left--;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    opcode    = ALU;
    br_taken  = 1'b0;
    br_target = '0;
    stall_req = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({pc_sel, flush_o, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 000",
               {pc_sel, flush_o, busy});
    end
    n_chk++;
    if (pc_target !== 32'h0 || br_cnt !== '0
        || br_taken_cnt !== '0 || jmp_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_val: tgt=%h cnt=%0d/%0d/%0d expected 0",
               pc_target, br_cnt, br_taken_cnt, jmp_cnt);
    end
  endtask

  task automatic test_beq_taken();
    apply_reset();
    ex_valid  = 1'b1;
    opcode    = BR;
    br_taken  = 1'b1;
    br_target = 32'h100;
    tick();
    idle_in();
    n_chk++;
    if ({pc_sel, flush_o} !== 2'b11 || pc_target !== 32'h100) begin
      n_fail++;
      $display("FAIL beq_n1: sel/fl=%b tgt=%h expected 11 100",
               {pc_sel, flush_o}, pc_target);
    end
    tick();
    n_chk++;
    if ({pc_sel, flush_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL beq_n2: sel/fl=%b expected 01",
               {pc_sel, flush_o});
    end
    tick();
    n_chk++;
    if ({pc_sel, flush_o, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL beq_n3: got %b expected 000",
               {pc_sel, flush_o, busy});
    end
    n_chk++;
    if (br_cnt !== 4'd1 || br_taken_cnt !== 4'd1
        || pc_target !== 32'h100) begin
      n_fail++;
      $display("FAIL beq_cnt: %0d/%0d tgt=%h expected 1/1 100",
               br_cnt, br_taken_cnt, pc_target);
    end
  endtask

  task automatic test_not_taken();
    apply_reset();
    ex_valid  = 1'b1;
    opcode    = BR;
    br_taken  = 1'b0;
    br_target = 32'h200;
    tick();
    idle_in();
    n_chk++;
    if ({pc_sel, flush_o, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL bne_ctl: got %b expected 000",
               {pc_sel, flush_o, busy});
    end
    tick();
    n_chk++;
    if (br_cnt !== 4'd1 || br_taken_cnt !== 4'd0
        || pc_target !== 32'h0) begin
      n_fail++;
      $display("FAIL bne_cnt: %0d/%0d tgt=%h expected 1/0 0",
               br_cnt, br_taken_cnt, pc_target);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    ex_valid  = 1'b1;
    opcode    = JAL;
    br_taken  = 1'b1;
    br_target = 32'h3c0;
    stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({pc_sel, flush_o, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %b expected 000",
                 i, {pc_sel, flush_o, busy});
      end
    end
    stall_req = 1'b0;
    tick();
    idle_in();
    n_chk++;
    if (pc_sel !== 1'b1 || pc_target !== 32'h3c0) begin
      n_fail++;
      $display("FAIL stall_redir: sel=%b tgt=%h expected 1 3c0",
               pc_sel, pc_target);
    end
    tick();
    stall_req = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({pc_sel, flush_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_flush: sel/fl=%b expected 01",
               {pc_sel, flush_o});
    end
    stall_req = 1'b0;
    tick();
    n_chk++;
    if (flush_o !== 1'b0 || jmp_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL stall_end: fl=%b jmp=%0d expected 0 1",
               flush_o, jmp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ex_valid  = 1'b1;
    opcode    = BR;
    br_taken  = 1'b1;
    br_target = 32'h440;
    tick();
    br_target = 32'h880;
    n_chk++;
    if (pc_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_n1: sel=%b expected 1", pc_sel);
    end
    tick();
    n_chk++;
    if ({pc_sel, flush_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_n2: sel/fl=%b expected 01",
               {pc_sel, flush_o});
    end
    tick();
    idle_in();
    n_chk++;
    if (busy !== 1'b0 || br_cnt !== 4'd1
        || br_taken_cnt !== 4'd1 || pc_target !== 32'h440) begin
      n_fail++;
      $display("FAIL b2b_end: busy=%b cnt=%0d/%0d tgt=%h exp 0 1/1 440",
               busy, br_cnt, br_taken_cnt, pc_target);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    ex_valid = 1'b1;
    opcode   = JALR;
    br_taken = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) begin
        n_chk++;
        if (jmp_cnt !== 4'd15) begin
          n_fail++;
          $display("FAIL sat_15: jmp=%0d expected 15", jmp_cnt);
        end
      end
    end
    n_chk++;
    if (jmp_cnt !== 4'd15 || br_cnt !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_20: jmp=%0d br=%0d busy=%b expected 15 0 0",
               jmp_cnt, br_cnt, busy);
    end
    cnt_clr = 1'b1;
    tick();
    idle_in();
    n_chk++;
    if (jmp_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_prio: jmp=%0d expected 0", jmp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ex_valid  = 1'b1;
    opcode    = BR;
    br_taken  = 1'b1;
    br_target = 32'h500;
    tick();
    idle_in();
    n_chk++;
    if (pc_sel !== 1'b1 || br_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rmid_pre: sel=%b br=%0d expected 1 1",
               pc_sel, br_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({pc_sel, flush_o, busy} !== 3'b000 || br_cnt !== '0
        || br_taken_cnt !== '0 || pc_target !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_async: ctl=%b br=%0d tk=%0d tgt=%h exp 0",
               {pc_sel, flush_o, busy}, br_cnt, br_taken_cnt,
               pc_target);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      r         = $urandom_range(0, 7);
      ex_valid  = ($urandom_range(0, 3) != 0);
      opcode    = (r < 3) ? BR : (r < 5) ? JAL : (r < 6) ? JALR
                : 7'($urandom);
      br_taken  = $urandom_range(0, 1) == 1;
      br_target = $urandom;
      stall_req = ($urandom_range(0, 3) == 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      tick();
      n_chk++;
      if (pc_sel !== (m_left == FC) || flush_o !== (m_left > 0)
          || busy !== (m_left > 0) || pc_target !== m_tgt) begin
        n_fail++;
        $display("FAIL rnd_ctl c%0d: sel=%b fl=%b busy=%b tgt=%h exp left=%0d tgt=%h",
                 c, pc_sel, flush_o, busy, pc_target, m_left, m_tgt);
      end
      n_chk++;
      if (int'(br_cnt) != m_br || int'(br_taken_cnt) != m_tk
          || int'(jmp_cnt) != m_jmp) begin
        n_fail++;
        $display("FAIL rnd_cnt c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 c, br_cnt, br_taken_cnt, jmp_cnt, m_br, m_tk, m_jmp);
      end
    end
    idle_in();
  endtask

  initial begin
    model_reset();
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
